// File: rtl/morse_pkg.sv
// Element encoding, ASCII constants and the pure Morse code lookup.
// Build option: define MORSE_PUNCT_EN to decode the punctuation codes.
package morse_pkg;

   typedef enum logic {
      DOT  = 1'b0,
      DASH = 1'b1
   } morse_elem_e;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;

   localparam int unsigned LOOKUP_CODE_W = 6;
   localparam int unsigned LOOKUP_LEN_W  = 4;

   // code holds the elements MSB-first in its low len bits, dash=1
   function automatic logic [7:0] morse_lookup(input logic [LOOKUP_CODE_W-1:0] code,
                                               input logic [LOOKUP_LEN_W-1:0]  len);
      logic [7:0] ch;
      ch = ASCII_QMARK;
      case (len)
         4'd1: ch = code[0] ? "T" : "E";
         4'd2: begin
            case (code[1:0])
               2'b00:   ch = "I";
               2'b01:   ch = "A";
               2'b10:   ch = "N";
               default: ch = "M";
            endcase
         end
         4'd3: begin
            case (code[2:0])
               3'b000:  ch = "S";
               3'b001:  ch = "U";
               3'b010:  ch = "R";
               3'b011:  ch = "W";
               3'b100:  ch = "D";
               3'b101:  ch = "K";
               3'b110:  ch = "G";
               default: ch = "O";
            endcase
         end
         4'd4: begin
            case (code[3:0])
               4'b0000: ch = "H";
               4'b0001: ch = "V";
               4'b0010: ch = "F";
               4'b0100: ch = "L";
               4'b0110: ch = "P";
               4'b0111: ch = "J";
               4'b1000: ch = "B";
               4'b1001: ch = "X";
               4'b1010: ch = "C";
               4'b1011: ch = "Y";
               4'b1100: ch = "Z";
               4'b1101: ch = "Q";
               default: ch = ASCII_QMARK;
            endcase
         end
         4'd5: begin
            case (code[4:0])
               5'b01111: ch = "1";
               5'b00111: ch = "2";
               5'b00011: ch = "3";
               5'b00001: ch = "4";
               5'b00000: ch = "5";
               5'b10000: ch = "6";
               5'b11000: ch = "7";
               5'b11100: ch = "8";
               5'b11110: ch = "9";
               5'b11111: ch = "0";
`ifdef MORSE_PUNCT_EN
               5'b10010: ch = "/";
`endif
               default:  ch = ASCII_QMARK;
            endcase
         end
         4'd6: begin
            case (code[5:0])
`ifdef MORSE_PUNCT_EN
               6'b010101: ch = ".";
               6'b110011: ch = ",";
               6'b001100: ch = "?";
               6'b100001: ch = "-";
`endif
               default:   ch = ASCII_QMARK;
            endcase
         end
         default: ch = ASCII_QMARK;
      endcase
      return ch;
   endfunction

endpackage

// File: rtl/morse_stream_decoder_if.sv
// Element input strobes and decoded-character valid/ready stream.
interface morse_stream_decoder_if;
   logic       sym_valid;
   logic       sym_dash;
   logic       sym_undo;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_char;

   modport master (
      input  sym_valid, sym_dash, sym_undo, out_ready,
      output out_valid, out_char
   );

   modport slave (
      output sym_valid, sym_dash, sym_undo, out_ready,
      input  out_valid, out_char
   );
endinterface

// File: rtl/morse_char_fifo.sv
// Synchronous 8-bit character FIFO; a push while full only lands with a same-cycle pop.
module morse_char_fifo #(
   parameter  int unsigned FIFO_DEPTH = 8,
   localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH),
   localparam int unsigned CNT_W      = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push,
   input  logic [7:0]       wdata,
   input  logic             pop,
   output logic [7:0]       rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_en_c;
   logic             rd_en_c;

   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign rd_en_c = pop && !empty;
   assign wr_en_c = push && (!full || rd_en_c);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en_c) mem[wr_ptr] <= wdata;
   end

   // Pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_en_c) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_en_c, rd_en_c})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/morse_stream_decoder.sv
// Morse element accumulator with programmable character/word gaps feeding an ASCII FIFO.
// Build option: MORSE_PUNCT_EN (see morse_pkg) enables punctuation decode.
module morse_stream_decoder
   import morse_pkg::*;
#(
   parameter  int unsigned MAX_SYMS   = 6,
   parameter  int unsigned CNT_W      = 32,
   parameter  int unsigned FIFO_DEPTH = 8,
   localparam int unsigned LEN_W      = $clog2(MAX_SYMS + 1),
   localparam int unsigned FCNT_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [CNT_W-1:0]      char_gap_cycles,
   input  logic [CNT_W-1:0]      word_gap_cycles,
   morse_stream_decoder_if.master bus,
   output logic [FCNT_W-1:0]     fifo_count,
   output logic [LEN_W-1:0]      pending_len,
   output logic                  overflow,
   output logic                  busy
);

   logic [MAX_SYMS-1:0] code;
   logic                code_err;
   logic                space_armed;
   logic [CNT_W-1:0]    cnt;

   logic [CNT_W-1:0] char_gap_c;
   logic [CNT_W-1:0] sat_c;
   logic             word_en_c;
   logic             evt_undo_c;
   logic             evt_sym_c;
   logic             idle_c;
   logic             char_fire_c;
   logic             word_fire_c;
   logic             push_c;
   logic             pop_c;
   logic [7:0]       push_data_c;
   logic [7:0]       rdata;
   logic             full;
   logic             empty;

   // Gap configuration, event priority and decode/space firing
   always_comb begin
      char_gap_c  = (char_gap_cycles == '0) ? CNT_W'(1) : char_gap_cycles;
      word_en_c   = word_gap_cycles > char_gap_c;
      sat_c       = word_en_c ? word_gap_cycles : char_gap_c;
      evt_undo_c  = bus.sym_undo && (pending_len != '0);
      evt_sym_c   = !bus.sym_undo && bus.sym_valid;
      idle_c      = !clear && enable && !evt_undo_c && !evt_sym_c;
      char_fire_c = idle_c && (pending_len != '0) && (cnt == char_gap_c);
      word_fire_c = idle_c && word_en_c && space_armed && (pending_len == '0)
                    && (cnt == word_gap_cycles);
      push_c      = char_fire_c || word_fire_c;
      push_data_c = ASCII_SPACE;
      if (char_fire_c) begin
         push_data_c = code_err ? ASCII_QMARK
                                : morse_lookup(LOOKUP_CODE_W'(code), LOOKUP_LEN_W'(pending_len));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear || !enable) begin
         code        <= '0;
         code_err    <= 1'b0;
         pending_len <= '0;
         cnt         <= '0;
         space_armed <= 1'b0;
      end else if (evt_undo_c) begin
         code        <= code >> 1;
         pending_len <= pending_len - LEN_W'(1);
         code_err    <= 1'b0;
         cnt         <= '0;
      end else if (evt_sym_c) begin
         cnt <= '0;
         if (pending_len == LEN_W'(MAX_SYMS)) begin
            code_err <= 1'b1;
         end else begin
            code        <= {code[MAX_SYMS-2:0], (bus.sym_dash == 1'(DASH))};
            pending_len <= pending_len + LEN_W'(1);
         end
      end else begin
         if (cnt < sat_c) cnt <= cnt + CNT_W'(1);
         if (char_fire_c) begin
            code        <= '0;
            code_err    <= 1'b0;
            pending_len <= '0;
            space_armed <= 1'b1;
         end else if (word_fire_c) begin
            space_armed <= 1'b0;
         end
      end
   end

   // Sticky record of a character lost to a full FIFO
   always_ff @(posedge clk) begin
      if (!rst_n || clear)                 overflow <= 1'b0;
      else if (push_c && full && !pop_c)   overflow <= 1'b1;
   end

   assign pop_c         = bus.out_valid && bus.out_ready;
   assign bus.out_valid = !empty;
   assign bus.out_char  = empty ? 8'h00 : rdata;
   assign busy          = (pending_len != '0) || space_armed;

   morse_char_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .push  (push_c),
      .wdata (push_data_c),
      .pop   (pop_c),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_morse_stream_decoder.sv
// Scoreboard bench for morse_stream_decoder: directed element sequences, queue-checked output stream.
module tb_morse_stream_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        clear;
   logic [31:0] char_gap;
   logic [31:0] word_gap;
   logic [2:0]  fifo_count;
   logic [2:0]  pending_len;
   logic        overflow;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q[$];

`ifdef MORSE_PUNCT_EN
   localparam logic [7:0] PUNCT_EXP = 8'h2E;
`else
   localparam logic [7:0] PUNCT_EXP = 8'h3F;
`endif

   morse_stream_decoder_if bus();

   morse_stream_decoder #(.MAX_SYMS(6), .CNT_W(32), .FIFO_DEPTH(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .enable          (enable),
      .clear           (clear),
      .char_gap_cycles (char_gap),
      .word_gap_cycles (word_gap),
      .bus             (bus),
      .fifo_count      (fifo_count),
      .pending_len     (pending_len),
      .overflow        (overflow),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic dash);
      bus.sym_valid = 1'b1;
      bus.sym_dash  = dash;
      tick(1);
      bus.sym_valid = 1'b0;
      bus.sym_dash  = 1'b0;
   endtask

   // Elements MSB-first from the low len bits of code, one idle cycle between
   task automatic send(input logic [7:0] code, input int len);
      for (int i = len - 1; i >= 0; i--) begin
         pulse(code[i]);
         if (i != 0) tick(1);
      end
   endtask

   // Monitor: every accepted head entry must match the next expected character
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got 0x%0h, expected no character", bus.out_char);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (bus.out_char !== e) begin
               n_fail++;
               $display("FAIL sb_char: got 0x%0h, expected 0x%0h", bus.out_char, e);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n         = 1'b0;
      enable        = 1'b1;
      clear         = 1'b0;
      char_gap      = 32'd4;
      word_gap      = 32'd10;
      bus.sym_valid = 1'b0;
      bus.sym_dash  = 1'b0;
      bus.sym_undo  = 1'b0;
      bus.out_ready = 1'b0;
      tick(2);
      rst_n = 1'b1;

      check("rst_out_valid",   32'(bus.out_valid), 32'd0);
      check("rst_out_char",    32'(bus.out_char),  32'h00);
      check("rst_fifo_count",  32'(fifo_count),    32'd0);
      check("rst_pending_len", 32'(pending_len),   32'd0);
      check("rst_overflow",    32'(overflow),      32'd0);
      check("rst_busy",        32'(busy),          32'd0);

      // 1: exact decode latency for 'A'
      pulse(1'b0);
      tick(1);
      pulse(1'b1);
      tick(4);
      check("lat_valid_c7", 32'(bus.out_valid), 32'd0);
      tick(1);
      check("lat_valid_c8", 32'(bus.out_valid), 32'd1);
      check("lat_char_c8",  32'(bus.out_char),  32'h41);
      exp_q.push_back(8'h41);
      exp_q.push_back(8'h20);
      bus.out_ready = 1'b1;
      tick(30);

      // 2: digit, six-element punctuation, over-length character
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h20);
      send(8'b11111, 5);
      tick(30);
      exp_q.push_back(PUNCT_EXP);
      exp_q.push_back(8'h20);
      send(8'b010101, 6);
      tick(30);
      exp_q.push_back(8'h3F);
      exp_q.push_back(8'h20);
      send(8'b0, 7);
      check("maxlen_pending", 32'(pending_len), 32'd6);
      tick(30);

      // 3: one space per word gap
      exp_q.push_back(8'h45);
      exp_q.push_back(8'h20);
      send(8'b0, 1);
      tick(30);
      check("word_busy", 32'(busy), 32'd0);
      tick(30);
      check("word_no_more_valid", 32'(bus.out_valid), 32'd0);
      check("word_no_more_count", 32'(fifo_count),    32'd0);

      // 4a: overflow on a fifth push into a full FIFO
      bus.out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         send(8'b0, 1);
         tick(6);
      end
      check("ovf_count", 32'(fifo_count), 32'd4);
      check("ovf_flag",  32'(overflow),   32'd1);
      tick(10);
      for (int k = 0; k < 4; k++) exp_q.push_back(8'h45);
      bus.out_ready = 1'b1;
      tick(10);
      check("ovf_drain_valid", 32'(bus.out_valid), 32'd0);
      check("ovf_drain_count", 32'(fifo_count),    32'd0);
      check("ovf_sticky",      32'(overflow),      32'd1);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'd0);

      // 4b: push and pop in the same cycle on a full FIFO
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         send(8'b0, 1);
         tick(6);
      end
      check("pp_full_count", 32'(fifo_count), 32'd4);
      for (int k = 0; k < 5; k++) exp_q.push_back(8'h45);
      exp_q.push_back(8'h20);
      pulse(1'b0);
      tick(4);
      bus.out_ready = 1'b1;
      tick(1);
      bus.out_ready = 1'b0;
      check("pp_count",    32'(fifo_count), 32'd4);
      check("pp_overflow", 32'(overflow),   32'd0);
      bus.out_ready = 1'b1;
      tick(30);

      // 5: undo, undo when empty, clear beating sym_valid
      exp_q.push_back(8'h45);
      exp_q.push_back(8'h20);
      pulse(1'b0);
      tick(1);
      pulse(1'b1);
      tick(1);
      bus.sym_undo = 1'b1;
      tick(1);
      bus.sym_undo = 1'b0;
      check("undo_pending", 32'(pending_len), 32'd1);
      tick(30);
      bus.sym_undo = 1'b1;
      tick(1);
      bus.sym_undo = 1'b0;
      check("undo_empty_pending", 32'(pending_len), 32'd0);
      check("undo_empty_count",   32'(fifo_count),  32'd0);
      check("undo_empty_busy",    32'(busy),        32'd0);
      bus.out_ready = 1'b0;
      send(8'b0, 1);
      tick(6);
      check("clr_setup_count", 32'(fifo_count), 32'd1);
      pulse(1'b0);
      clear         = 1'b1;
      bus.sym_valid = 1'b1;
      tick(1);
      clear         = 1'b0;
      bus.sym_valid = 1'b0;
      check("clr_pending", 32'(pending_len), 32'd0);
      check("clr_count",   32'(fifo_count),  32'd0);
      check("clr_busy",    32'(busy),        32'd0);
      bus.out_ready = 1'b1;
      tick(30);
      check("clr_no_space", 32'(fifo_count), 32'd0);

      // 6a: reset mid-character empties everything
      bus.out_ready = 1'b0;
      send(8'b0, 1);
      tick(6);
      check("rst6_setup_count", 32'(fifo_count), 32'd1);
      send(8'b101, 3);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      check("rst6_pending", 32'(pending_len),   32'd0);
      check("rst6_busy",    32'(busy),          32'd0);
      check("rst6_count",   32'(fifo_count),    32'd0);
      check("rst6_valid",   32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b1;
      tick(30);
      check("rst6_idle_count", 32'(fifo_count), 32'd0);

      // 6b: enable drop mid-character keeps the FIFO
      bus.out_ready = 1'b0;
      send(8'b0, 1);
      tick(6);
      send(8'b101, 3);
      enable = 1'b0;
      tick(1);
      enable = 1'b1;
      check("en_pending", 32'(pending_len), 32'd0);
      check("en_busy",    32'(busy),        32'd0);
      check("en_count",   32'(fifo_count),  32'd1);
      exp_q.push_back(8'h45);
      bus.out_ready = 1'b1;
      tick(30);
      check("en_idle_count", 32'(fifo_count), 32'd0);

      for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/morse_stream_decoder.md
Name: morse_stream_decoder

Overview:
Parametrised successor to the Morse decode UI, without any LCD coupling. It accumulates dot/dash elements, decodes each on a programmable inter-character gap, and emits a space on a separate programmable word gap. Decoded ASCII goes into an internal FIFO with a valid/ready output. It sits between the key-event decoder and any consumer: LCD UI, UART echo or a text buffer.

Parameters:
MAX_SYMS, 6, maximum elements per character (legal range 5..8); sets the width of the code register.
CNT_W, 32, width of the gap counter and of the gap-config inputs.
FIFO_DEPTH, 8, output FIFO entries; must be a power of 2, at least 2.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
enable  in  1  low = flush the accumulator and hold the counter at 0; FIFO contents are kept
sym_valid  in  1  one-cycle element strobe
sym_dash  in  1  qualifies sym_valid: 1 = dash, 0 = dot
sym_undo  in  1  one-cycle strobe; removes the newest pending element
clear  in  1  one-cycle strobe; flushes accumulator, FIFO and overflow flag
char_gap_cycles  in  CNT_W  idle cycles before a character is decoded; value 0 is treated as 1
word_gap_cycles  in  CNT_W  idle cycles before a space is emitted; ignored when not greater than char_gap_cycles
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts the head entry
out_char  out  8  ASCII at the FIFO head; 0x00 when empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
pending_len  out  $clog2(MAX_SYMS+1)  elements currently accumulated
overflow  out  1  sticky; a push was dropped because the FIFO was full
busy  out  1  pending_len != 0 or a space is armed

Behaviour:
- Reset (rst_n low at a clk edge): accumulator, counter and FIFO are emptied.
  - out_valid=0, out_char=0x00, fifo_count=0, pending_len=0, overflow=0, busy=0.
  - space_armed=0, code_err=0.
  - Reset applied mid-character discards the partial code; no character is emitted.
- Priority within one cycle, highest first: clear > !enable > sym_undo > sym_valid > gap events.
- Element accepted:
  - Code register shifts left and the new bit enters at the LSB (dash=1).
  - pending_len increments and the counter resets to 0.
  - If pending_len==MAX_SYMS, the element is dropped and code_err is set; the counter still resets.
- Undo:
  - When pending_len>0: code shifts right, pending_len decrements, code_err clears, counter resets.
  - When pending_len==0: no effect.
- Counter:
  - Increments every cycle that has no accepted event.
  - Saturates at max(char_gap, word_gap).
- Character decode:
  - Fires in the cycle where the counter equals char_gap and pending_len>0.
  - Pushes lookup(code, len), or 0x3F ('?') if code_err is set or the code is unmapped.
  - Clears the accumulator and sets space_armed.
  - Latency: last element at cycle t gives counter 0 at t+1, push at t+1+N, out_valid high at t+2+N.
- Word gap:
  - Fires in the cycle where the counter equals word_gap, pending_len==0 and space_armed=1.
  - Pushes 0x20 and clears space_armed, so at most one space per gap.
  - A space is never emitted at start-up or after clear.
- Lookup table:
  - Letters A-Z (lengths 1-4) and digits 0-9 (length 5).
  - Lengths 6..MAX_SYMS map to '?' unless the optional feature is enabled.
- FIFO:
  - A pop occurs when out_valid and out_ready are both high.
  - A push while full is dropped and sets overflow, unless a pop occurs in the same cycle; then both take effect and the count is unchanged.
  - Push and pop on an empty FIFO: the push is stored and out_valid rises the next cycle (no bypass).
  - Pointers wrap modulo FIFO_DEPTH.
- clear: within 1 cycle, FIFO is emptied, overflow=0, accumulator is flushed, counter=0, space_armed=0.
- enable low: accumulator flushed, counter=0, space_armed=0; FIFO still drains through out_ready.

Optional Feature:
MORSE_PUNCT_EN
- Defined: 6-element codes decode as follows.
  - .-.-.- gives '.'
  - --..-- gives ','
  - ..--.. gives '?'
  - -....- gives '-'
  - -..-. (5 elements) gives '/'
- Undefined: all of these codes give 0x3F; the lookup logic is not synthesised.

Decomposition:
- morse_pkg holds:
  - element encoding constants (DOT=0, DASH=1);
  - ASCII constants (space, '?');
  - the pure lookup function morse_lookup(code, len), including the punctuation branch under the macro.
- Sub-module morse_char_fifo: synchronous FIFO, parameter FIFO_DEPTH, 8-bit data, ports push/pop/full/empty/count. It is instantiated once.

Test Plan:
1. CHAR_GAP=4, WORD_GAP=10; dot at cycle 0, dash at cycle 2 -> push at cycle 7; out_valid=1 with out_char=0x41 ('A') at cycle 8.
2. Five dashes then idle -> 0x30 ('0'). Sequence .-.-.- -> 0x2E with MORSE_PUNCT_EN, 0x3F without. Seven dots with MAX_SYMS=6 -> 0x3F.
3. dot, idle 30 cycles with out_ready=1 -> reads 0x45 then exactly one 0x20. Another 30 idle cycles -> no further push.
4. FIFO_DEPTH=4, out_ready=0, five 'E' characters -> fifo_count=4 and overflow=1 after the 5th. Then out_ready=1 -> four 0x45 reads followed by out_valid=0. Full FIFO with a same-cycle push and pop -> count stays 4 and overflow is not set.
5. dot, dash, undo -> 0x45 ('E'). Undo with pending_len=0 -> no change. clear asserted together with sym_valid -> pending_len=0 and fifo_count=0.
6. rst_n low for 1 edge after 3 elements (and after enable drops mid-character) -> pending_len=0, busy=0, no output character; FIFO is preserved for the enable case and emptied for the reset case.
